// File: rtl/alu_4_issue.sv
// alu_4_issue: multicycle issue front end for an external 4-bit ALU; cmd valid/ready in, alu_a/b/ctrl out, alu_y in, 2-entry rsp valid/ready buffer out, done_cnt
module alu_4_issue #(
  parameter int SETTLE = 2,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [7:0]       alu_y,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_y,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_err,
  output logic [15:0]      done_cnt
);
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CAPTURE} state_t;
  state_t r_st, w_nst;
  logic [3:0] r_cnt, r_a, r_b, r_op;
  logic [TAG_W-1:0] r_tag;
  logic r_rdy, r_rp, r_wp;
  logic [1:0] r_n;
  logic [15:0] r_done;
  logic [7:0] r_fy [2];
  logic [TAG_W-1:0] r_ft [2];
  logic r_fe [2];
  logic w_acc, w_ill, w_pop, w_push, w_cap, w_pe;
  logic [7:0] w_py;
  logic [TAG_W-1:0] w_pt;
  logic [1:0] w_n_nx;
  always_comb begin
    w_acc = cmd_valid && r_rdy;
    w_ill = cmd_op >= 4'd10;
    w_cap = r_st == S_CAPTURE;
    w_pop = (r_n != 2'd0) && rsp_ready;
    w_push = (w_acc && w_ill) || w_cap;
    w_py = w_cap ? alu_y : 8'h00;
    w_pt = w_cap ? r_tag : cmd_tag;
    w_pe = !w_cap;
    w_n_nx = r_n + 2'(w_push) - 2'(w_pop);
    w_nst = r_st == S_IDLE ? ((w_acc && !w_ill) ? S_SETTLE : S_IDLE) :
            r_st == S_SETTLE ? ((r_cnt == 4'd0) ? S_CAPTURE : S_SETTLE) : S_IDLE;
  end
  // cmd_ready is registered from the next-cycle occupancy, so rsp_ready only reaches it through a flop
  always_ff @(posedge clk) begin
    if (rst) begin
      r_st <= S_IDLE;
      r_rdy <= 1'b0;
      r_cnt <= '0;
      r_a <= '0;
      r_b <= '0;
      r_op <= '0;
      r_tag <= '0;
      r_rp <= 1'b0;
      r_wp <= 1'b0;
      r_n <= '0;
      r_done <= '0;
      r_fy <= '{default: '0};
      r_ft <= '{default: '0};
      r_fe <= '{default: 1'b0};
    end else begin
      r_st <= w_nst;
      r_rdy <= (w_nst == S_IDLE) && (w_n_nx != 2'd2);
      if (w_acc && !w_ill) begin
        r_a <= cmd_a;
        r_b <= cmd_b;
        r_op <= cmd_op;
        r_tag <= cmd_tag;
        r_cnt <= 4'(SETTLE - 1);
      end else if (r_st == S_SETTLE) r_cnt <= r_cnt - 4'd1;
      if (w_push) begin
        r_fy[r_wp] <= w_py;
        r_ft[r_wp] <= w_pt;
        r_fe[r_wp] <= w_pe;
        r_wp <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_n <= w_n_nx;
      r_done <= r_done + 16'(w_pop);
    end
  end
  assign cmd_ready = r_rdy;
  assign alu_a = r_a;
  assign alu_b = r_b;
  assign alu_ctrl = r_op;
  assign rsp_valid = r_n != 2'd0;
  assign rsp_y = r_fy[r_rp];
  assign rsp_tag = r_ft[r_rp];
  assign rsp_err = r_fe[r_rp];
  assign done_cnt = r_done;
endmodule
